// File: rtl/alu_pkg.sv
// Shared opcode, command-entry and FSM definitions for the ALU command sequencer.
// ALU_SEQ_CHAIN_EN adds a per-entry chain bit that substitutes the previous result for operand a.
package alu_pkg;

  localparam logic [3:0] OP_ADD          = 4'd0;
  localparam logic [3:0] OP_SUB          = 4'd1;
  localparam logic [3:0] OP_MUL          = 4'd2;
  localparam logic [3:0] OP_CMP          = 4'd3;
  localparam logic [3:0] OP_SHR4         = 4'd4;
  localparam logic [3:0] OP_ADD_CONST_1  = 4'd5;
  localparam logic [3:0] OP_SUB_CONST_1  = 4'd6;
  localparam logic [3:0] OP_MUL_CONST_10 = 4'd7;
  localparam logic [3:0] OP_MUL_CONST_3  = 4'd8;
  localparam logic [3:0] OP_FPMUL        = 4'd9;
  localparam logic [3:0] OP_MUL_CONST_8  = 4'd10;
  localparam logic [3:0] OP_FP_NORMALIZE = 4'd11;

  localparam logic [3:0] OP_IDLE       = 4'hF;
  localparam logic [3:0] OP_LAST_LEGAL = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_RESP  = 2'd2
  } seq_state_t;

  typedef struct packed {
`ifdef ALU_SEQ_CHAIN_EN
    logic        chain;
`endif
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
  } cmd_entry_t;

  localparam int CMD_W = $bits(cmd_entry_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with combinational read of the head entry; full/empty from an extra pointer bit.
// Push is ignored when full and pop when empty; synchronous active-high clear.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues tagged ALU commands, drives them one at a time to the combinational ALU, and returns in-order responses
// SETTLE+2 cycles after acceptance; stalls in RESP under rsp_ready backpressure. Optional feature: ALU_SEQ_CHAIN_EN.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic [3:0]  cmd_tag,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic        cmd_chain,
`endif
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_fp_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic        rsp_fp_error,
  output logic [3:0]  rsp_tag,
  output logic        rsp_illegal,
  output logic        busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  seq_state_t  state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]  alu_op_q, tag_q, rsp_tag_q;
  logic [15:0] alu_a_q, alu_b_q, rsp_result_q;
  logic        rsp_valid_q, rsp_zero_q, rsp_carry_q, rsp_fp_error_q, rsp_illegal_q;

  cmd_entry_t  push_entry, pop_entry;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [15:0] pop_a;

  assign push_entry.op  = cmd_op;
  assign push_entry.a   = cmd_a;
  assign push_entry.b   = cmd_b;
  assign push_entry.tag = cmd_tag;

`ifdef ALU_SEQ_CHAIN_EN
  logic [15:0] last_result_q;

  assign push_entry.chain = cmd_chain;
  assign pop_a = pop_entry.chain ? last_result_q : pop_entry.a;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_result_q <= '0;
    end else if (state_q == S_DRIVE && cnt_q == '0) begin
      last_result_q <= alu_result;
    end
  end
`else
  assign pop_a = pop_entry.a;
`endif

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;
  assign fifo_pop  = (state_q == S_IDLE) && !fifo_empty;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (push_entry),
    .pop      (fifo_pop),
    .pop_dat  (pop_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      alu_op_q       <= OP_IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      tag_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_carry_q    <= 1'b0;
      rsp_fp_error_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;
      rsp_tag_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fifo_pop) begin
            alu_op_q <= pop_entry.op;
            alu_a_q  <= pop_a;
            alu_b_q  <= pop_entry.b;
            tag_q    <= pop_entry.tag;
            cnt_q    <= CW'(SETTLE - 1);
            state_q  <= S_DRIVE;
          end else begin
            alu_op_q <= OP_IDLE;
          end
        end
        S_DRIVE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            // Illegal opcodes still go to the ALU; its output is reported as-is.
            rsp_result_q   <= alu_result;
            rsp_zero_q     <= alu_zero;
            rsp_carry_q    <= alu_carry;
            rsp_fp_error_q <= alu_fp_error;
            rsp_illegal_q  <= (alu_op_q > OP_LAST_LEGAL);
            rsp_tag_q      <= tag_q;
            rsp_valid_q    <= 1'b1;
            state_q        <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            alu_op_q    <= OP_IDLE;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign alu_op       = alu_op_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_fp_error = rsp_fp_error_q;
  assign rsp_illegal  = rsp_illegal_q;
  assign rsp_tag      = rsp_tag_q;
  assign busy         = (state_q != S_IDLE) || !fifo_empty;

endmodule
